axi_lite_master_bridge: RTL and testbench

Synthesizable AXI4-Lite initiator that converts a simple single-outstanding command/response interface into AXI4-Lite read and write transactions. It sits between on-chip control logic (sequencers, CPU-less init engines) and AXI4-Lite register slaves such as `aix_slave_bus`. It also replaces the behavioural master model wherever real hardware must drive the slave.

---
 rtl/axi_lite_master_bridge.sv | 157 +++++++++++++++
 tb/tb_axi_lite_master_bridge.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_master_bridge.sv
// Single-outstanding command/response to AXI4-Lite initiator.
// One command at a time becomes one AXI4-Lite read or write; the response is held until consumed.
module axi_lite_master_bridge #(
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_M_AXI_ADDR_WIDTH = 8
) (
  input  logic                            M_AXI_ACLK,
  input  logic                            M_AXI_ARESETN,

  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic                            cmd_write,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,

  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic                            rsp_write,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]                      rsp_resp,
  output logic [7:0]                      err_count,

  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]                      M_AXI_AWPROT,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]                      M_AXI_ARPROT,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY
);

  // state   | meaning
  // IDLE    | cmd_ready high, waiting for a command
  // WR_REQ  | AW and W offered, each dropped at its own handshake
  // WR_RESP | BREADY high, waiting for BVALID
  // RD_REQ  | AR offered
  // RD_RESP | RREADY high, waiting for RVALID
  // RSP     | response presented on rsp_*, waiting for rsp_ready
  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP} state_t;

  state_t state;
  logic   aw_fin;
  logic   w_fin;

  assign M_AXI_AWPROT = 3'b000;
  assign M_AXI_ARPROT = 3'b000;

  // A channel is finished once its VALID is low or is being accepted this edge.
  assign aw_fin = !M_AXI_AWVALID || M_AXI_AWREADY;
  assign w_fin  = !M_AXI_WVALID  || M_AXI_WREADY;

  function automatic logic [7:0] bump_err(input logic [7:0] cnt, input logic [1:0] resp);
    return (resp != 2'b00 && cnt != 8'hFF) ? cnt + 8'd1 : cnt;
  endfunction

  always_ff @(posedge M_AXI_ACLK) begin
    if (!M_AXI_ARESETN) begin
      state         <= IDLE;
      cmd_ready     <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_write     <= 1'b0;
      rsp_rdata     <= '0;
      rsp_resp      <= 2'b00;
      err_count     <= 8'h00;
      M_AXI_AWADDR  <= '0;
      M_AXI_AWVALID <= 1'b0;
      M_AXI_WDATA   <= '0;
      M_AXI_WSTRB   <= '0;
      M_AXI_WVALID  <= 1'b0;
      M_AXI_BREADY  <= 1'b0;
      M_AXI_ARADDR  <= '0;
      M_AXI_ARVALID <= 1'b0;
      M_AXI_RREADY  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            if (cmd_write) begin
              M_AXI_AWADDR  <= cmd_addr;
              M_AXI_WDATA   <= cmd_wdata;
              M_AXI_WSTRB   <= cmd_wstrb;
              M_AXI_AWVALID <= 1'b1;
              M_AXI_WVALID  <= 1'b1;
              state         <= WR_REQ;
            end else begin
              M_AXI_ARADDR  <= cmd_addr;
              M_AXI_ARVALID <= 1'b1;
              state         <= RD_REQ;
            end
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        WR_REQ: begin
          if (M_AXI_AWREADY) M_AXI_AWVALID <= 1'b0;
          if (M_AXI_WREADY)  M_AXI_WVALID  <= 1'b0;
          if (aw_fin && w_fin) begin
            M_AXI_BREADY <= 1'b1;
            state        <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (M_AXI_BVALID) begin
            M_AXI_BREADY <= 1'b0;
            rsp_write    <= 1'b1;
            rsp_rdata    <= '0;
            rsp_resp     <= M_AXI_BRESP;
            err_count    <= bump_err(err_count, M_AXI_BRESP);
            state        <= RSP;
          end
        end
        RD_REQ: begin
          if (M_AXI_ARREADY) begin
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b1;
            state         <= RD_RESP;
          end
        end
        RD_RESP: begin
          if (M_AXI_RVALID) begin
            M_AXI_RREADY <= 1'b0;
            rsp_write    <= 1'b0;
            rsp_rdata    <= M_AXI_RDATA;
            rsp_resp     <= M_AXI_RRESP;
            err_count    <= bump_err(err_count, M_AXI_RRESP);
            state        <= RSP;
          end
        end
        RSP: begin
          // rsp_valid rises one edge after capture; cmd_ready returns one edge after release.
          if (!rsp_valid) begin
            rsp_valid <= 1'b1;
          end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_master_bridge.sv
// Bench for axi_lite_master_bridge: stub AXI4-Lite slave with programmable stalls and
// response codes, checked against an array-based memory and error-counter model.
module tb_axi_lite_master_bridge;

  logic        M_AXI_ACLK = 1'b0;
  logic        M_AXI_ARESETN;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [7:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_write;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [7:0]  err_count;
  logic [7:0]  M_AXI_AWADDR, M_AXI_ARADDR;
  logic [2:0]  M_AXI_AWPROT, M_AXI_ARPROT;
  logic        M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
  logic [31:0] M_AXI_WDATA, M_AXI_RDATA;
  logic [3:0]  M_AXI_WSTRB;
  logic [1:0]  M_AXI_BRESP, M_AXI_RRESP;
  logic        M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
  logic        M_AXI_RVALID, M_AXI_RREADY;

  axi_lite_master_bridge #(.C_M_AXI_DATA_WIDTH(32), .C_M_AXI_ADDR_WIDTH(8)) dut (
    .M_AXI_ACLK(M_AXI_ACLK), .M_AXI_ARESETN(M_AXI_ARESETN),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .err_count(err_count),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT),
    .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
    .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
    .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
    .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
    .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT),
    .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
    .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
  );

  always #5 M_AXI_ACLK = ~M_AXI_ACLK;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] slave_mem [64];
  logic [31:0] model_mem [64];
  logic [7:0]  model_err;
  logic [31:0] last_rdata;
  logic [1:0]  last_resp;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                        input logic [3:0] strb);
    logic [31:0] r = old;
    for (int i = 0; i < 4; i++) if (strb[i]) r[8*i +: 8] = data[8*i +: 8];
    return r;
  endfunction

  task automatic chk_cleared(input string tag);
    chk({tag, "_ctl"}, {cmd_ready, rsp_valid, rsp_write, M_AXI_AWVALID, M_AXI_WVALID,
                        M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY}, 0);
    chk({tag, "_err"}, err_count, 0);
    chk({tag, "_rdata"}, rsp_rdata, 0);
    chk({tag, "_resp"}, rsp_resp, 0);
    chk({tag, "_addr"}, {M_AXI_AWADDR, M_AXI_ARADDR, M_AXI_WSTRB}, 0);
    chk({tag, "_wdata"}, M_AXI_WDATA, 0);
  endtask

  // One full command -> AXI -> response transaction with the stub slave in the loop.
  task automatic run_txn(input logic wr, input logic [7:0] addr, input logic [31:0] wdata,
                         input logic [3:0] strb, input int aw_dly, input int w_dly,
                         input int ar_dly, input int resp_dly, input logic [1:0] code,
                         input int hold);
    int t = 0, aw_cnt = 0, w_cnt = 0, ar_cnt = 0, b_cnt = 0, r_cnt = 0, hold_cnt = 0;
    int aw_hs = 0, w_hs = 0, ar_hs = 0, b_hs = 0, r_hs = 0, t_rsp = -1, exp_lat;
    bit b_drop = 0, r_drop = 0, rsp_seen = 0, rsp_done = 0;
    logic [7:0]  aw_cap = '0, ar_cap = '0;
    logic [31:0] wd_cap = '0, cap_rdata = '0, exp_rdata;
    logic [3:0]  ws_cap = '0;
    logic [1:0]  cap_resp = '0;
    logic        cap_write = 1'b0;

    while (cmd_ready !== 1'b1 && t < 50) begin @(negedge M_AXI_ACLK); t++; end
    chk("cmd_ready_wait", cmd_ready, 1);
    exp_rdata = wr ? 32'h0 : model_mem[addr[7:2]];
    exp_lat   = 3 + resp_dly + (wr ? ((aw_dly > w_dly) ? aw_dly : w_dly) : ar_dly);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata; cmd_wstrb = strb;
    @(posedge M_AXI_ACLK);
    t = 0;
    while (!rsp_done && t < 200) begin
      @(negedge M_AXI_ACLK);
      cmd_valid = 1'b0;
      if (t == 0) chk("cmd_ready_drop", cmd_ready, 0);
      if (wr) chk("no_read_in_write", {M_AXI_ARVALID, M_AXI_RREADY}, 0);
      else    chk("no_write_in_read", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY}, 0);

      if (b_drop) begin
        M_AXI_BVALID = 1'b0; b_drop = 0;
        chk("bready_drop", M_AXI_BREADY, 0);
      end else if (wr && aw_hs > 0 && w_hs > 0 && b_hs == 0) begin
        chk("bready_on", M_AXI_BREADY, 1);
        if (b_cnt >= resp_dly) begin
          M_AXI_BVALID = 1'b1; M_AXI_BRESP = code;
          if (M_AXI_BREADY) begin
            b_hs++; b_drop = 1;
            if (code == 2'b00) slave_mem[aw_cap[7:2]] = merge(slave_mem[aw_cap[7:2]], wd_cap, ws_cap);
          end
        end else b_cnt++;
      end else if (wr) chk("bready_off", M_AXI_BREADY, 0);

      if (M_AXI_AWVALID) begin
        chk("awaddr_hold", M_AXI_AWADDR, addr);
        if (aw_cnt >= aw_dly) begin M_AXI_AWREADY = 1'b1; aw_hs++; aw_cap = M_AXI_AWADDR; end
        else begin M_AXI_AWREADY = 1'b0; aw_cnt++; end
      end else M_AXI_AWREADY = 1'b0;

      if (M_AXI_WVALID) begin
        chk("wdata_hold", M_AXI_WDATA, wdata);
        chk("wstrb_hold", M_AXI_WSTRB, strb);
        if (w_cnt >= w_dly) begin
          M_AXI_WREADY = 1'b1; w_hs++; wd_cap = M_AXI_WDATA; ws_cap = M_AXI_WSTRB;
        end else begin M_AXI_WREADY = 1'b0; w_cnt++; end
      end else M_AXI_WREADY = 1'b0;

      if (r_drop) begin
        M_AXI_RVALID = 1'b0; r_drop = 0;
        chk("rready_drop", M_AXI_RREADY, 0);
      end else if (!wr && ar_hs > 0 && r_hs == 0) begin
        chk("rready_on", M_AXI_RREADY, 1);
        if (r_cnt >= resp_dly) begin
          M_AXI_RVALID = 1'b1; M_AXI_RRESP = code; M_AXI_RDATA = slave_mem[ar_cap[7:2]];
          if (M_AXI_RREADY) begin r_hs++; r_drop = 1; end
        end else r_cnt++;
      end else if (!wr) chk("rready_off", M_AXI_RREADY, 0);

      if (M_AXI_ARVALID) begin
        chk("araddr_hold", M_AXI_ARADDR, addr);
        if (ar_cnt >= ar_dly) begin M_AXI_ARREADY = 1'b1; ar_hs++; ar_cap = M_AXI_ARADDR; end
        else begin M_AXI_ARREADY = 1'b0; ar_cnt++; end
      end else M_AXI_ARREADY = 1'b0;

      if (!rsp_seen && rsp_valid === 1'b1) begin
        rsp_seen = 1; t_rsp = t;
        cap_rdata = rsp_rdata; cap_resp = rsp_resp; cap_write = rsp_write;
        chk("cmd_ready_busy", cmd_ready, 0);
      end else if (rsp_seen) begin
        chk("rsp_valid_hold", rsp_valid, 1);
        chk("rsp_rdata_hold", rsp_rdata, cap_rdata);
        chk("rsp_resp_hold", rsp_resp, cap_resp);
        chk("rsp_write_hold", rsp_write, cap_write);
        chk("cmd_ready_busy", cmd_ready, 0);
      end else chk("rsp_valid_early", rsp_valid, 0);
      if (rsp_seen) begin
        if (hold_cnt >= hold) begin rsp_ready = 1'b1; rsp_done = 1; end
        else hold_cnt++;
      end
      t++;
    end
    chk("txn_timeout", rsp_done, 1);
    if (rsp_done) begin
      @(negedge M_AXI_ACLK);
      rsp_ready = 1'b0;
      chk("rsp_valid_release", rsp_valid, 0);
      chk("cmd_ready_gap", cmd_ready, 0);
      @(negedge M_AXI_ACLK);
      chk("cmd_ready_back", cmd_ready, 1);
    end
    cmd_valid = 1'b0; rsp_ready = 1'b0;
    M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0; M_AXI_BVALID = 1'b0;
    M_AXI_ARREADY = 1'b0; M_AXI_RVALID = 1'b0;

    if (wr && code == 2'b00) model_mem[addr[7:2]] = merge(model_mem[addr[7:2]], wdata, strb);
    if (code != 2'b00 && model_err != 8'hFF) model_err = model_err + 8'd1;
    chk("rsp_write", cap_write, wr);
    chk("rsp_rdata", cap_rdata, exp_rdata);
    chk("rsp_resp", cap_resp, code);
    chk("err_count", err_count, model_err);
    chk("latency", t_rsp, exp_lat);
    chk("aw_handshakes", aw_hs, wr ? 1 : 0);
    chk("w_handshakes", w_hs, wr ? 1 : 0);
    chk("b_handshakes", b_hs, wr ? 1 : 0);
    chk("ar_handshakes", ar_hs, wr ? 0 : 1);
    chk("r_handshakes", r_hs, wr ? 0 : 1);
    last_rdata = cap_rdata;
    last_resp  = cap_resp;
  endtask

  initial begin
    logic        wr;
    logic [1:0]  code;
    M_AXI_ARESETN = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    rsp_ready = 1'b0;
    M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0; M_AXI_BVALID = 1'b0; M_AXI_BRESP = 2'b00;
    M_AXI_ARREADY = 1'b0; M_AXI_RVALID = 1'b0; M_AXI_RDATA = '0; M_AXI_RRESP = 2'b00;
    for (int i = 0; i < 64; i++) begin slave_mem[i] = '0; model_mem[i] = '0; end
    model_err = 8'h00;

    repeat (3) @(negedge M_AXI_ACLK);
    chk_cleared("reset");
    chk("prot", {M_AXI_AWPROT, M_AXI_ARPROT}, 0);
    M_AXI_ARESETN = 1'b1;
    @(negedge M_AXI_ACLK);
    chk("cmd_ready_after_reset", cmd_ready, 1);

    // Basic write then read-back
    run_txn(1'b1, 8'h04, 32'h1234_5678, 4'hF, 0, 0, 0, 0, 2'b00, 0);
    chk("wr4_resp", last_resp, 2'b00);
    run_txn(1'b0, 8'h04, 32'h0, 4'h0, 0, 0, 0, 0, 2'b00, 0);
    chk("rd4_rdata", last_rdata, 32'h1234_5678);
    chk("rd4_err", err_count, 0);

    // Byte strobe
    run_txn(1'b1, 8'h08, 32'h0, 4'hF, 0, 0, 0, 0, 2'b00, 0);
    run_txn(1'b1, 8'h08, 32'hAABB_CCDD, 4'h1, 0, 0, 0, 0, 2'b00, 0);
    run_txn(1'b0, 8'h08, 32'h0, 4'h0, 0, 0, 0, 0, 2'b00, 0);
    chk("strb_rdata", last_rdata, 32'h0000_00DD);

    // AW/W skew in both orders and together
    run_txn(1'b1, 8'h10, 32'hCAFE_0001, 4'hF, 3, 0, 0, 0, 2'b00, 0);
    run_txn(1'b1, 8'h14, 32'hCAFE_0002, 4'hF, 0, 3, 0, 0, 2'b00, 0);
    run_txn(1'b1, 8'h18, 32'hCAFE_0003, 4'hF, 2, 2, 0, 1, 2'b00, 0);

    // Response back-pressure
    run_txn(1'b0, 8'h10, 32'h0, 4'h0, 0, 0, 1, 2, 2'b00, 5);
    chk("bp_rdata", last_rdata, 32'hCAFE_0001);

    // Error responses
    run_txn(1'b0, 8'h20, 32'h0, 4'h0, 0, 0, 0, 0, 2'b10, 0);
    chk("slverr_resp", last_resp, 2'b10);
    run_txn(1'b1, 8'h24, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 0, 2'b11, 0);
    chk("decerr_resp", last_resp, 2'b11);
    chk("err_count_two", err_count, 8'd2);

    // Randomized mix against the model
    for (int n = 0; n < 40; n++) begin
      wr   = 1'($urandom);
      code = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      run_txn(wr, 8'($urandom), $urandom, 4'($urandom), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
              code, $urandom_range(0, 2));
    end

    // Drive the error counter into saturation
    for (int n = 0; n < 300; n++)
      run_txn(1'($urandom), 8'($urandom), $urandom, 4'hF, 0, 0, 0, 0,
              2'($urandom_range(1, 3)), 0);
    chk("err_count_saturated", err_count, 8'hFF);

    // Reset while waiting for R
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h0C;
    @(negedge M_AXI_ACLK);
    cmd_valid = 1'b0;
    chk("abort_arvalid", M_AXI_ARVALID, 1);
    M_AXI_ARREADY = 1'b1;
    @(negedge M_AXI_ACLK);
    M_AXI_ARREADY = 1'b0;
    chk("abort_rready", M_AXI_RREADY, 1);
    repeat (2) @(negedge M_AXI_ACLK);
    chk("abort_rready_wait", M_AXI_RREADY, 1);
    M_AXI_ARESETN = 1'b0;
    @(negedge M_AXI_ACLK);
    chk_cleared("abort");
    model_err = 8'h00;
    M_AXI_ARESETN = 1'b1;
    @(negedge M_AXI_ACLK);
    chk("abort_cmd_ready", cmd_ready, 1);
    repeat (4) begin
      @(negedge M_AXI_ACLK);
      chk("abort_no_rsp", rsp_valid, 0);
    end

    // Recovery after abort
    run_txn(1'b0, 8'h04, 32'h0, 4'h0, 0, 0, 0, 0, 2'b00, 0);
    chk("recover_rdata", last_rdata, 32'h1234_5678);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
